// File: rtl/led_sequencer.sv
// led_sequencer: prescaled LED pattern generator for the board LED bank.
// A free-running prescaler produces a step tick; on each tick a position
// register walks down, walks up, bounces or fills according to 'mode'.
// The LED bank and the step strobe are both registered and change together.
// The mode sampled on a tick only steers that tick's position and LED
// update, so no separate copy of it is kept between ticks.
module led_sequencer #(
  parameter int N_LEDS        = 8,
  parameter int PRESCALE_BITS = 23
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        mode,
  output logic [N_LEDS-1:0] LED,
  output logic              step
);

  localparam int PW = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
  localparam logic [PW-1:0] LAST    = PW'(N_LEDS - 1);
  localparam logic [PW-1:0] POS_ONE = PW'(1);
  localparam logic [PRESCALE_BITS-1:0] CNT_ONE = PRESCALE_BITS'(1);
  localparam logic [N_LEDS-1:0] RESET_LED = {1'b1, {(N_LEDS-1){1'b0}}};

  typedef enum logic [1:0] {
    MODE_DOWN   = 2'd0,
    MODE_UP     = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_FILL   = 2'd3
  } mode_t;

  logic [PRESCALE_BITS-1:0] cnt;
  logic [PW-1:0]            pos;
  logic                     dir;
  logic                     tick;
  logic [PW-1:0]            posNext;
  logic                     dirNext;
  logic [N_LEDS-1:0]        pattern;
  mode_t                    modeSel;

  assign tick    = en && (cnt == '1);
  assign modeSel = mode_t'(mode);

  // Next position and direction; wrap is explicit so non-power-of-two banks work.
  always_comb begin
    posNext = pos;
    dirNext = dir;
    case (modeSel)
      MODE_DOWN: begin
        posNext = (pos == '0) ? LAST : pos - POS_ONE;
        dirNext = 1'b0;
      end
      MODE_UP, MODE_FILL: begin
        posNext = (pos == LAST) ? '0 : pos + POS_ONE;
        dirNext = 1'b1;
      end
      MODE_BOUNCE: begin
        if (dir) begin
          if (pos == LAST) begin
            posNext = pos - POS_ONE;
            dirNext = 1'b0;
          end else begin
            posNext = pos + POS_ONE;
          end
        end else begin
          if (pos == '0) begin
            posNext = pos + POS_ONE;
            dirNext = 1'b1;
          end else begin
            posNext = pos - POS_ONE;
          end
        end
      end
      default: begin
        posNext = pos;
        dirNext = dir;
      end
    endcase
  end

  // LED image for the next position: thermometer in fill mode, one-hot otherwise.
  always_comb begin
    pattern = '0;
    for (int i = 0; i < N_LEDS; i++) begin
      if (modeSel == MODE_FILL) begin
        pattern[i] = (i <= int'(posNext));
      end else begin
        pattern[i] = (i == int'(posNext));
      end
    end
  end

  // Prescaler, sequencer state and registered outputs; reset wins over enable and tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      pos  <= LAST;
      dir  <= 1'b0;
      LED  <= RESET_LED;
      step <= 1'b0;
    end else begin
      step <= tick;
      if (en) begin
        cnt <= cnt + CNT_ONE;
      end
      if (tick) begin
        pos <= posNext;
        dir <= dirNext;
        LED <= pattern;
      end
    end
  end

endmodule
